// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the instruction/data bus arbiter: FSM state encoding and
// bus transfer size codes.
package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_I_ADDR = 3'd1,
    ST_I_WAIT = 3'd2,
    ST_D_ADDR = 3'd3,
    ST_D_WAIT = 3'd4
  } arb_state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } bus_size_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one addr_ok/data_ok SRAM-like bus between the fetch and load/store
// ports, one outstanding transaction at a time, with fetch flush support.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_done,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stallreq_for_bus
);

  arb_state_t        state, state_nxt;
  logic              discard, discard_nxt;
  logic              grant_data, grant_inst;
  logic              req_wr;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt  = state;
    grant_data = 1'b0;
    grant_inst = 1'b0;
    bus_req    = 1'b0;
    inst_done  = 1'b0;
    data_done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (data_req) begin
          grant_data = 1'b1;
          state_nxt  = ST_D_ADDR;
        end else if (inst_req && !inst_cancel) begin
          grant_inst = 1'b1;
          state_nxt  = ST_I_ADDR;
        end
      end
      ST_I_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) state_nxt = ST_I_WAIT;
      end
      ST_I_WAIT: begin
        if (bus_data_ok) begin
          inst_done = !discard && !inst_cancel;
          state_nxt = ST_IDLE;
        end
      end
      ST_D_ADDR: begin
        bus_req = 1'b1;
        if (bus_addr_ok) state_nxt = ST_D_WAIT;
      end
      ST_D_WAIT: begin
        if (bus_data_ok) begin
          data_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A flushed fetch still finishes on the bus; only its done is dropped.
    discard_nxt = discard;
    if (state_nxt == ST_IDLE)
      discard_nxt = 1'b0;
    else if ((state == ST_I_ADDR || state == ST_I_WAIT) && inst_cancel)
      discard_nxt = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      discard      <= 1'b0;
      req_wr       <= 1'b0;
      req_size     <= 2'd0;
      req_addr     <= '0;
      req_wdata    <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      discard <= discard_nxt;
      if (grant_data) begin
        req_wr    <= data_wr;
        req_size  <= data_size;
        req_addr  <= data_addr;
        req_wdata <= data_wdata;
      end else if (grant_inst) begin
        req_wr    <= 1'b0;
        req_size  <= SIZE_WORD;
        req_addr  <= inst_addr;
        req_wdata <= '0;
      end
      if (inst_done) inst_rdata_q <= bus_rdata;
      if (data_done) data_rdata_q <= bus_rdata;
    end
  end

  // Bus fields come from the captured request so they stay stable under
  // backpressure even if the requester ports move.
  assign bus_wr    = req_wr;
  assign bus_size  = req_size;
  assign bus_addr  = req_addr;
  assign bus_wdata = req_wdata;

  assign inst_rdata = inst_done ? bus_rdata : inst_rdata_q;
  assign data_rdata = data_done ? bus_rdata : data_rdata_q;

  assign stallreq_for_bus = (inst_req && !inst_done && !inst_cancel) ||
                            (data_req && !data_done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model and a reactive bus slave.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req, inst_cancel, inst_done;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr, data_done;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata, data_rdata;
  logic          bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic          stallreq_for_bus;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_done(inst_done), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_done(data_done), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_for_bus(stallreq_for_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: the one transaction that owns the bus, if any.
  typedef struct packed {
    logic        valid;
    logic        is_inst;
    logic        wr;
    logic        acc;
    logic        disc;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        cur = '0;
  logic [31:0] m_inst_hold = '0;
  logic [31:0] m_data_hold = '0;

  // Bus slave and requester agent knobs
  bit          sl_busy = 1'b0;
  int          sl_cnt = 0, ah_cnt = 0, addr_wait = 0, data_lat = 1;
  bit          auto_req = 1'b0, strays = 1'b0, use_fixed = 1'b0;
  logic [31:0] fixed_rdata = '0;
  int          idone_cnt = 0, ddone_cnt = 0;

  // Drive window: called 1 time unit after the rising edge.
  task automatic drive();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    if (sl_busy) begin
      if (sl_cnt == 0) bus_data_ok = 1'b1;
      else sl_cnt--;
    end else if (bus_req) begin
      if (ah_cnt >= addr_wait) bus_addr_ok = 1'b1;
      else ah_cnt++;
    end
    if (strays) begin
      if (!sl_busy && !bus_req && $urandom_range(7) == 0) bus_data_ok = 1'b1;
      if (!bus_req && $urandom_range(7) == 0) bus_addr_ok = 1'b1;
    end
    bus_rdata = (use_fixed && bus_data_ok) ? fixed_rdata : $urandom;
    if (auto_req) begin
      inst_cancel = ($urandom_range(15) == 0);
      if (inst_cancel && inst_req) inst_addr = {$urandom} & 32'hFFFF_FFFC;
      if (!inst_req && $urandom_range(3) == 0) begin
        inst_req  = 1'b1;
        inst_addr = {$urandom} & 32'hFFFF_FFFC;
      end
      if (!data_req && $urandom_range(4) == 0) begin
        data_req   = 1'b1;
        data_wr    = $urandom_range(1);
        data_size  = 2'($urandom_range(2));
        data_addr  = $urandom;
        data_wdata = $urandom;
      end
    end
  endtask

  // Check outputs mid-cycle, let requesters react, advance model to the edge.
  task automatic tick();
    logic        e_breq, e_idone, e_ddone, e_stall;
    logic [31:0] e_ird, e_drd;
    #1;
    e_breq  = cur.valid && !cur.acc;
    e_idone = cur.valid && cur.is_inst && cur.acc && bus_data_ok && !cur.disc && !inst_cancel;
    e_ddone = cur.valid && !cur.is_inst && cur.acc && bus_data_ok;
    e_ird   = e_idone ? bus_rdata : m_inst_hold;
    e_drd   = e_ddone ? bus_rdata : m_data_hold;
    e_stall = (inst_req && !e_idone && !inst_cancel) || (data_req && !e_ddone);
    check("bus_req", bus_req, e_breq);
    if (e_breq) begin
      check("bus_wr", bus_wr, cur.wr);
      check("bus_size", bus_size, cur.size);
      check("bus_addr", bus_addr, cur.addr);
      check("bus_wdata", bus_wdata, cur.wdata);
    end
    check("inst_done", inst_done, e_idone);
    check("data_done", data_done, e_ddone);
    check("inst_rdata", inst_rdata, e_ird);
    check("data_rdata", data_rdata, e_drd);
    check("stallreq", stallreq_for_bus, e_stall);

    if (inst_done) begin idone_cnt++; inst_req = 1'b0; end
    if (data_done) begin ddone_cnt++; data_req = 1'b0; end

    if (rst) begin
      cur = '0;
      m_inst_hold = '0;
      m_data_hold = '0;
    end else begin
      if (e_idone) m_inst_hold = bus_rdata;
      if (e_ddone) m_data_hold = bus_rdata;
      if (cur.valid) begin
        if (cur.is_inst && inst_cancel) cur.disc = 1'b1;
        if (cur.acc && bus_data_ok) cur = '0;
        else if (!cur.acc && bus_addr_ok) cur.acc = 1'b1;
      end else if (data_req) begin
        cur = '0;
        cur.valid = 1'b1; cur.wr = data_wr; cur.size = data_size;
        cur.addr = data_addr; cur.wdata = data_wdata;
      end else if (inst_req && !inst_cancel) begin
        cur = '0;
        cur.valid = 1'b1; cur.is_inst = 1'b1; cur.size = 2'd2;
        cur.addr = inst_addr;
      end
    end

    // The slave deliberately ignores rst so its late data_ok lands as a stray.
    if (sl_busy) begin
      if (bus_data_ok) sl_busy = 1'b0;
    end else if (bus_req && bus_addr_ok) begin
      sl_busy = 1'b1;
      sl_cnt  = data_lat - 1;
      ah_cnt  = 0;
      if (auto_req) begin
        addr_wait = $urandom_range(3);
        data_lat  = 1 + $urandom_range(2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin drive(); tick(); end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while ((inst_req || data_req || cur.valid || sl_busy) && k < budget) begin
      drive();
      tick();
      k++;
    end
    check({tag, "_timeout"}, 32'(k < budget), 32'd1);
  endtask

  int i0, d0;

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = '0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    @(posedge clk);
    #1;
    run_cycles(2);
    rst = 1'b0;
    run_cycles(2);

    // Single fetch: addr_ok at cycle 1, data_ok at cycle 3
    addr_wait = 0; data_lat = 2; use_fixed = 1'b1; fixed_rdata = 32'h2408_0001;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    i0 = idone_cnt;
    wait_idle(20, "fetch");
    run_cycles(2);
    check("fetch_done_count", 32'(idone_cnt - i0), 32'd1);
    check("fetch_rdata_hold", inst_rdata, 32'h2408_0001);

    // Contention: store wins over fetch
    data_lat = 1; use_fixed = 1'b0;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
    data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
    drive(); tick();
    check("contention_first_wr", bus_wr, 1'b1);
    check("contention_first_addr", bus_addr, 32'h8000_0010);
    wait_idle(30, "contention");

    // Cancel while in I_WAIT
    data_lat = 3;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
    i0 = idone_cnt;
    run_cycles(2);
    inst_cancel = 1'b1; inst_req = 1'b0;
    drive(); tick();
    inst_cancel = 1'b0;
    wait_idle(20, "cancel");
    check("cancel_no_done", 32'(idone_cnt - i0), 32'd0);
    inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
    wait_idle(20, "refetch");
    check("refetch_done", 32'(idone_cnt - i0), 32'd1);

    // Backpressure: addr_ok withheld for 5 cycles
    addr_wait = 5; data_lat = 1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
    wait_idle(30, "backpressure");
    addr_wait = 0;

    // Byte load, then hold across idle cycles until the next load
    use_fixed = 1'b1; fixed_rdata = 32'h1122_3344;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h8000_0003;
    drive(); tick();
    check("byte_bus_size", bus_size, 2'd0);
    check("byte_bus_addr", bus_addr, 32'h8000_0003);
    wait_idle(20, "byte_load");
    run_cycles(3);
    check("byte_rdata_hold", data_rdata, 32'h1122_3344);
    fixed_rdata = 32'hAABB_CCDD;
    data_req = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0020;
    wait_idle(20, "word_load");
    run_cycles(1);
    check("word_rdata_hold", data_rdata, 32'hAABB_CCDD);

    // Reset during D_WAIT; the slave's late data_ok must be ignored
    use_fixed = 1'b0; data_lat = 6;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_0040;
    d0 = ddone_cnt;
    run_cycles(2);
    rst = 1'b1; data_req = 1'b0;
    drive(); tick();
    rst = 1'b0;
    check("reset_data_rdata", data_rdata, 32'd0);
    check("reset_inst_rdata", inst_rdata, 32'd0);
    wait_idle(20, "reset_drain");
    check("reset_no_done", 32'(ddone_cnt - d0), 32'd0);

    // Randomized traffic with flushes and stray handshakes
    i0 = idone_cnt; d0 = ddone_cnt;
    auto_req = 1'b1; strays = 1'b1;
    run_cycles(3000);
    auto_req = 1'b0; strays = 1'b0; inst_cancel = 1'b0;
    wait_idle(200, "drain");
    check("random_progress", 32'((idone_cnt - i0) > 10 && (ddone_cnt - d0) > 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Arbitrates the IF-stage instruction fetch port and the MEM-stage load/store port onto one shared SRAM-like bus with an addr_ok/data_ok handshake. At most one transaction is outstanding at a time. stallreq_for_bus goes to the pipeline stall controller and holds the pipeline until every pending request completes. It also handles fetch cancellation on a pipeline flush.

Parameters:
ADDR_W, 32, address width of requester and bus ports
DATA_W, 32, data width of requester and bus ports

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
inst_req  in  1  fetch request, level; held until inst_done
inst_addr  in  ADDR_W  fetch address; stable while inst_req is high
inst_cancel  in  1  flush pulse; discards the current or pending fetch
inst_done  out  1  fetch complete, one-cycle pulse
inst_rdata  out  DATA_W  fetch data
data_req  in  1  load/store request, level; held until data_done
data_wr  in  1  1 = store, 0 = load
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data
data_done  out  1  load/store complete, one-cycle pulse
data_rdata  out  DATA_W  load data
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  address accepted
bus_data_ok  in  1  data returned / write done
bus_rdata  in  DATA_W  bus read data
stallreq_for_bus  out  1  stall request to the stall controller

Behaviour:
- FSM states: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT.
- Registers: captured request (wr, size, addr, wdata), discard flag, hold registers for inst_rdata and data_rdata.
- Reset: state = IDLE, discard = 0. bus_req, inst_done, data_done and stallreq_for_bus are 0. Captured regs, inst_rdata and data_rdata are 0.
- IDLE:
  - data_req has strict priority: go to D_ADDR and capture the data fields.
  - Otherwise, if inst_req && !inst_cancel: go to I_ADDR and capture inst_addr with wr = 0, size = 2.
- Bus drive:
  - bus_req = 1 only in I_ADDR or D_ADDR.
  - bus_wr, bus_size, bus_addr and bus_wdata come from the captured regs, not from the requester ports.
- x_ADDR: stay until bus_addr_ok. On the cycle bus_addr_ok is high, go to x_WAIT. bus_req stays high until then (no abort).
- x_WAIT: stay until bus_data_ok, then go to IDLE.
  - D_WAIT: data_done = bus_data_ok, combinational, same cycle.
  - I_WAIT: inst_done = bus_data_ok && !discard && !inst_cancel.
- Read data:
  - On done, the matching rdata output shows bus_rdata combinationally in that cycle.
  - bus_rdata is also latched into the hold register, and the output keeps that value until the next done of the same port.
- Minimum latency: request seen in IDLE at cycle 0 → bus_req at cycle 1 → addr_ok at cycle 1, data_ok at cycle 2 → done at cycle 2. The requester drops req in the done cycle, so the IDLE at cycle 3 does not re-issue.
- Cancel:
  - inst_cancel in I_ADDR or I_WAIT sets discard. The transaction still completes on the bus, but inst_done is suppressed.
  - discard clears on return to IDLE.
  - inst_cancel in IDLE blocks that cycle's fetch grant.
  - inst_cancel has no effect on data transactions.
- stallreq_for_bus = (inst_req && !inst_done && !inst_cancel) || (data_req && !data_done).
- Simultaneous inst_req and data_req in IDLE: data first, then inst via IDLE → I_ADDR.
- bus_data_ok in IDLE or x_ADDR (stale, e.g. after reset) is ignored. bus_addr_ok outside x_ADDR is ignored.
- Reset mid-transaction: forces IDLE with the reset values. Bus-side recovery is the bus slave's responsibility.

Decomposition:
- Add to defines.vh: the state encodings (3-bit), the size codes (BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2), and `BusStateBus.
- No sub-module. FSM, capture regs and hold regs are all in this single block.

Test Plan:
- Single fetch: inst_req = 1, inst_addr = 32'hBFC0_0000; addr_ok at cycle 1, data_ok at cycle 3 with rdata 32'h2408_0001 → bus_req high at cycles 1 only; inst_done pulse at cycle 3 with inst_rdata = 32'h2408_0001; stallreq_for_bus high for cycles 0–2 and low at cycle 3.
- Contention: inst_req and data_req (store, addr 32'h8000_0010, wdata 32'hDEAD_BEEF, size = 2) both high at cycle 0 → first bus_req has bus_wr = 1 and the store fields; data_done first, then the fetch is issued; stallreq_for_bus stays high until inst_done.
- Cancel in I_WAIT: inst_cancel pulse after addr_ok → bus_data_ok is consumed, inst_done stays 0, state returns to IDLE, and the next inst_req is re-fetched normally.
- Backpressure: bus_addr_ok held low for 5 cycles → bus_req and bus_addr are stable all 5 cycles; no done; stallreq_for_bus = 1.
- Byte load: data_size = 0, addr 32'h8000_0003 → bus_size = 0 and bus_addr unchanged; data_rdata holds its value after data_done until the next load.
- Reset mid-D_WAIT: rst asserted for one cycle → all outputs 0 the next cycle; a stray bus_data_ok afterward produces no data_done.
